// File: rtl/path_turn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : path_turn_sequencer
// Purpose  : Path-level node controller. Passes follower motor commands through
//            and takes over at each node to push, pivot and reacquire the line.
// Revision : 1.0 - initial release
// ============================================================================
module path_turn_sequencer #(
  parameter int unsigned DEPTH        = 16,
  parameter logic [11:0] THRESH       = 12'd900,
  parameter logic [19:0] SETTLE_CYC   = 20'd3125,
  parameter logic [19:0] TURN_MIN_CYC = 20'd31250,
  parameter logic [19:0] TURN_MAX_CYC = 20'd625000
) (
  input  logic        clk_3125KHz,
  input  logic        reset,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [1:0]  prog_data,
  input  logic        start,
  input  logic        node_flag,
  input  logic [11:0] middle,
  input  logic        lf_m1_a,
  input  logic        lf_m1_b,
  input  logic        lf_m2_a,
  input  logic        lf_m2_b,
  input  logic [3:0]  lf_dc1,
  input  logic [3:0]  lf_dc2,
  output logic        m1_a,
  output logic        m1_b,
  output logic        m2_a,
  output logic        m2_b,
  output logic [3:0]  dc1,
  output logic [3:0]  dc2,
  output logic [3:0]  step_idx,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  localparam logic [3:0] c_LAST_IDX     = 4'(DEPTH - 1);
  localparam logic [1:0] c_ACT_STRAIGHT = 2'b00;
  localparam logic [1:0] c_ACT_LEFT     = 2'b01;
  localparam logic [1:0] c_ACT_STOP     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FOLLOW     = 3'd1,
    S_SETTLE     = 3'd2,
    S_TURN_LEAVE = 3'd3,
    S_TURN_SEEK  = 3'd4,
    S_STOPPED    = 3'd5,
    S_ERROR      = 3'd6
  } state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_step_idx, w_step_next;
  logic [19:0] r_cnt, w_cnt_next;
  logic [1:0]  r_action, w_action_next;
  logic        r_node_q;
  logic [1:0]  r_table [DEPTH];
  logic        w_node_edge, w_prog_ok, w_advance;
  logic [3:0]  w_mot, w_dc1, w_dc2;

  assign w_node_edge = node_flag & ~r_node_q;
  assign w_prog_ok   = (r_state == S_IDLE) || (r_state == S_STOPPED) || (r_state == S_ERROR);
  assign step_idx    = r_step_idx;

  // Path table is deliberately outside the reset domain so a reset keeps the program.
  always_ff @(posedge clk_3125KHz) begin
    if (prog_we && w_prog_ok) r_table[prog_addr] <= prog_data;
  end

  always_comb begin
    w_state_next  = r_state;
    w_step_next   = r_step_idx;
    w_action_next = r_action;
    w_cnt_next    = '0;
    w_advance     = 1'b0;
    case (r_state)
      S_IDLE, S_STOPPED, S_ERROR: begin
        if (start) begin
          w_state_next = S_FOLLOW;
          w_step_next  = '0;
        end
      end
      S_FOLLOW: begin
        if (w_node_edge) begin
          if (r_table[r_step_idx] == c_ACT_STOP) begin
            w_state_next = S_STOPPED;
          end else begin
            w_action_next = r_table[r_step_idx];
            w_state_next  = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        w_cnt_next = r_cnt + 20'd1;
        if (r_cnt == SETTLE_CYC - 20'd1) begin
          if (r_action == c_ACT_STRAIGHT) begin
            w_advance = 1'b1;
          end else begin
            w_cnt_next   = '0;
            w_state_next = S_TURN_LEAVE;
          end
        end
      end
      // The count runs on into TURN_SEEK so the timeout covers the whole pivot.
      S_TURN_LEAVE: begin
        w_cnt_next = r_cnt + 20'd1;
        if (r_cnt == TURN_MIN_CYC - 20'd1) w_state_next = S_TURN_SEEK;
      end
      S_TURN_SEEK: begin
        w_cnt_next = r_cnt + 20'd1;
        if (middle > THRESH) begin
          w_advance = 1'b1;
        end else if (r_cnt == TURN_MAX_CYC - 20'd1) begin
          w_cnt_next   = '0;
          w_state_next = S_ERROR;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    if (w_advance) begin
      w_cnt_next = '0;
      if (r_step_idx == c_LAST_IDX) begin
        w_state_next = S_STOPPED;
      end else begin
        w_state_next = S_FOLLOW;
        w_step_next  = r_step_idx + 4'd1;
      end
    end
  end

  always_comb begin
    w_mot = '0;
    w_dc1 = '0;
    w_dc2 = '0;
    case (r_state)
      S_FOLLOW: begin
        w_mot = {lf_m1_a, lf_m1_b, lf_m2_a, lf_m2_b};
        w_dc1 = lf_dc1;
        w_dc2 = lf_dc2;
      end
      S_SETTLE: begin
        w_mot = 4'b1010;
        w_dc1 = 4'd5;
        w_dc2 = 4'd5;
      end
      S_TURN_LEAVE, S_TURN_SEEK: begin
        w_mot = (r_action == c_ACT_LEFT) ? 4'b0110 : 4'b1001;
        w_dc1 = 4'd6;
        w_dc2 = 4'd6;
      end
      default: ;
    endcase
  end

  // Status flags are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk_3125KHz or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_step_idx  <= '0;
      r_cnt       <= '0;
      r_action    <= '0;
      r_node_q    <= 1'b0;
      m1_a        <= 1'b0;
      m1_b        <= 1'b0;
      m2_a        <= 1'b0;
      m2_b        <= 1'b0;
      dc1         <= '0;
      dc2         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      r_state                <= w_state_next;
      r_step_idx             <= w_step_next;
      r_cnt                  <= w_cnt_next;
      r_action               <= w_action_next;
      r_node_q               <= node_flag;
      {m1_a, m1_b, m2_a, m2_b} <= w_mot;
      dc1                    <= w_dc1;
      dc2                    <= w_dc2;
      busy        <= (w_state_next != S_IDLE) && (w_state_next != S_STOPPED) &&
                     (w_state_next != S_ERROR);
      done        <= (w_state_next == S_STOPPED);
      timeout_err <= (w_state_next == S_ERROR);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_path_turn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_path_turn_sequencer
// Purpose  : Self-checking bench for path_turn_sequencer with shortened timers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_path_turn_sequencer;

  localparam logic [2:0] c_NONE = 3'b000;
  localparam logic [2:0] c_BUSY = 3'b100;
  localparam logic [2:0] c_DONE = 3'b010;
  localparam logic [2:0] c_ERR  = 3'b001;

  logic        clk_3125KHz = 1'b0;
  logic        reset;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [1:0]  prog_data;
  logic        start;
  logic        node_flag;
  logic [11:0] middle;
  logic        lf_m1_a, lf_m1_b, lf_m2_a, lf_m2_b;
  logic [3:0]  lf_dc1, lf_dc2;
  logic        m1_a, m1_b, m2_a, m2_b;
  logic [3:0]  dc1, dc2, step_idx;
  logic        busy, done, timeout_err;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] mot;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] st;
    logic [2:0] flg;
  } exp_t;

  typedef struct packed {
    logic [3:0] mot;
    logic [3:0] d1;
    logic [3:0] d2;
  } vec_t;

  exp_t  sb[$];
  string sb_nm[$];
  vec_t  vecs[6];

  path_turn_sequencer #(
    .DEPTH       (16),
    .THRESH      (12'd900),
    .SETTLE_CYC  (20'd20),
    .TURN_MIN_CYC(20'd50),
    .TURN_MAX_CYC(20'd200)
  ) dut (
    .clk_3125KHz(clk_3125KHz),
    .reset      (reset),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .start      (start),
    .node_flag  (node_flag),
    .middle     (middle),
    .lf_m1_a    (lf_m1_a),
    .lf_m1_b    (lf_m1_b),
    .lf_m2_a    (lf_m2_a),
    .lf_m2_b    (lf_m2_b),
    .lf_dc1     (lf_dc1),
    .lf_dc2     (lf_dc2),
    .m1_a       (m1_a),
    .m1_b       (m1_b),
    .m2_a       (m2_a),
    .m2_b       (m2_b),
    .dc1        (dc1),
    .dc2        (dc2),
    .step_idx   (step_idx),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err)
  );

  always #5 clk_3125KHz = ~clk_3125KHz;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk_3125KHz);
      #1;
    end
  endtask

  task automatic set_lf(input logic [3:0] mot, input logic [3:0] d1, input logic [3:0] d2);
    {lf_m1_a, lf_m1_b, lf_m2_a, lf_m2_b} = mot;
    lf_dc1 = d1;
    lf_dc2 = d2;
  endtask

  task automatic pop_cmp();
    exp_t        e;
    string       nm;
    logic [18:0] act;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard: empty queue at compare");
      return;
    end
    e  = sb.pop_front();
    nm = sb_nm.pop_front();
    act = {m1_a, m1_b, m2_a, m2_b, dc1, dc2, step_idx, busy, done, timeout_err};
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: got mot=%b dc=%0d/%0d step=%0d bde=%b, want mot=%b dc=%0d/%0d step=%0d bde=%b",
               nm, act[18:15], act[14:11], act[10:7], act[6:3], act[2:0],
               e.mot, e.d1, e.d2, e.st, e.flg);
    end
  endtask

  task automatic expect_after(input int n, input string nm, input logic [3:0] mot,
                              input logic [3:0] d1, input logic [3:0] d2,
                              input logic [3:0] st, input logic [2:0] flg);
    exp_t e;
    e.mot = mot; e.d1 = d1; e.d2 = d2; e.st = st; e.flg = flg;
    sb.push_back(e);
    sb_nm.push_back(nm);
    tick(n);
    pop_cmp();
  endtask

  task automatic expect_pass(input int n, input string nm, input logic [3:0] st,
                             input logic [2:0] flg);
    expect_after(n, nm, {lf_m1_a, lf_m1_b, lf_m2_a, lf_m2_b}, lf_dc1, lf_dc2, st, flg);
  endtask

  task automatic prog(input logic [3:0] a, input logic [1:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick(1);
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic rearm_node();
    node_flag = 1'b0;
    tick(2);
    node_flag = 1'b1;
  endtask

  initial begin
    vecs[0] = '{mot: 4'b1010, d1: 4'd9,  d2: 4'd9};
    vecs[1] = '{mot: 4'b0110, d1: 4'd1,  d2: 4'd15};
    vecs[2] = '{mot: 4'b1001, d1: 4'd15, d2: 4'd0};
    vecs[3] = '{mot: 4'b0000, d1: 4'd0,  d2: 4'd0};
    vecs[4] = '{mot: 4'b0101, d1: 4'd12, d2: 4'd3};
    vecs[5] = '{mot: 4'b1000, d1: 4'd7,  d2: 4'd8};

    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0;
    node_flag = 1'b0; middle = 12'd100;
    set_lf(4'b0101, 4'd3, 4'd11);
    tick(2);
    expect_after(0, "reset_state", 4'b0000, 0, 0, 0, c_NONE);
    reset = 1'b0;
    tick(1);

    // Entry 0 is written in the same cycle as start.
    prog(4'd1, 2'b00);
    prog(4'd2, 2'b11);
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 2'b01; start = 1'b1;
    tick(1);
    prog_we = 1'b0; start = 1'b0;
    expect_after(0, "start_follow", 4'b0000, 0, 0, 0, c_BUSY);

    for (int i = 0; i < 6; i++) begin
      set_lf(vecs[i].mot, vecs[i].d1, vecs[i].d2);
      expect_after(1, "passthrough", vecs[i].mot, vecs[i].d1, vecs[i].d2, 0, c_BUSY);
    end
    set_lf(4'b0101, 4'd3, 4'd11);
    tick(1);

    // Left turn at step 0 with reacquire well inside TURN_SEEK.
    node_flag = 1'b1;
    expect_pass(1, "node_edge_lag", 0, c_BUSY);
    expect_after(1,  "settle_first", 4'b1010, 5, 5, 0, c_BUSY);
    expect_after(19, "settle_last",  4'b1010, 5, 5, 0, c_BUSY);
    expect_after(1,  "pivot_left",   4'b0110, 6, 6, 0, c_BUSY);
    tick(79);
    middle = 12'd1000;
    expect_after(1, "reacq_edge", 4'b0110, 6, 6, 1, c_BUSY);
    expect_pass(1, "reacq_pass", 1, c_BUSY);
    middle = 12'd100;
    expect_pass(3, "no_retrigger", 1, c_BUSY);

    // Write while busy must be dropped; entry 2 stays a stop.
    prog(4'd2, 2'b00);
    rearm_node();
    expect_after(2,  "straight_settle", 4'b1010, 5, 5, 1, c_BUSY);
    expect_after(19, "straight_last",   4'b1010, 5, 5, 2, c_BUSY);
    expect_pass(1, "straight_follow", 2, c_BUSY);
    rearm_node();
    expect_pass(1, "stop_flag", 2, c_DONE);
    expect_after(1, "stopped_off", 4'b0000, 0, 0, 2, c_DONE);

    // Right turn with middle already high: exit exactly at first seek cycle.
    node_flag = 1'b0;
    prog(4'd0, 2'b10);
    prog(4'd1, 2'b01);
    middle = 12'd1000;
    pulse_start();
    expect_after(0, "restart_clear", 4'b0000, 0, 0, 0, c_BUSY);
    tick(1);
    node_flag = 1'b1;
    expect_after(22, "pivot_right", 4'b1001, 6, 6, 0, c_BUSY);
    expect_after(49, "min_hold",    4'b1001, 6, 6, 0, c_BUSY);
    expect_after(1,  "seek_exit",   4'b1001, 6, 6, 1, c_BUSY);
    expect_pass(1, "right_follow", 1, c_BUSY);
    middle = 12'd100;

    // Left turn at step 1 that never reacquires.
    rearm_node();
    expect_after(22,  "pivot_t",     4'b0110, 6, 6, 1, c_BUSY);
    expect_after(198, "pre_timeout", 4'b0110, 6, 6, 1, c_BUSY);
    expect_after(1,   "timeout",     4'b0110, 6, 6, 1, c_ERR);
    expect_after(1,   "err_off",     4'b0000, 0, 0, 1, c_ERR);

    // All-straight path from ERROR; node_flag held high across each SETTLE.
    node_flag = 1'b0;
    for (int a = 0; a < 16; a++) prog(4'(a), 2'b00);
    pulse_start();
    expect_after(0, "err_clear", 4'b0000, 0, 0, 0, c_BUSY);
    for (int i = 0; i < 16; i++) begin
      node_flag = 1'b0;
      expect_pass(2, "walk_pre", 4'(i), c_BUSY);
      node_flag = 1'b1;
      if (i < 15) expect_pass(22, "walk_post", 4'(i + 1), c_BUSY);
      else        expect_after(22, "walk_end", 4'b0000, 0, 0, 4'd15, c_DONE);
    end

    // Asynchronous reset during TURN_SEEK, then replay of the retained table.
    node_flag = 1'b0;
    prog(4'd0, 2'b01);
    pulse_start();
    rearm_node();
    expect_after(22, "pivot_replay", 4'b0110, 6, 6, 0, c_BUSY);
    tick(60);
    #2 reset = 1'b1;
    #1;
    expect_after(0, "async_reset", 4'b0000, 0, 0, 0, c_NONE);
    tick(1);
    reset = 1'b0;
    expect_after(2, "idle_hold", 4'b0000, 0, 0, 0, c_NONE);
    node_flag = 1'b0;
    pulse_start();
    rearm_node();
    expect_after(22, "replay_left", 4'b0110, 6, 6, 0, c_BUSY);
    tick(60);
    middle = 12'd1000;
    expect_pass(2, "replay_reacq", 1, c_BUSY);
    middle = 12'd100;
    rearm_node();
    expect_pass(22, "replay_straight", 2, c_BUSY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
